// File: rtl/adder_meas_pkg.sv
// Shared types and constants for the instrumented-adder measurement sequencer.
package adder_meas_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLEAR,
    RUN,
    STOP,
    REPORT
  } meas_state_e;

  // Default adder settle time and counter CDC settle time, in system clocks.
  localparam int DEF_SETTLE = 4;
  localparam int DEF_SYNC   = 2;

  // Result record: oscillator count, sampled sum and the sum-check flag.
  localparam int CNT_W     = 32;
  localparam int DEF_WIDTH = 32;
  localparam int RESULT_W  = CNT_W + DEF_WIDTH + 1;

endpackage

// File: rtl/meas_timer.sv
// Loadable down-counter shared by the settle, run and sync phases.
// Loading N gives N+1 cycles until done is seen, done stays high at zero.
module meas_timer #(
  parameter int WINDOW_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [WINDOW_W-1:0] load_val,
  output logic                done
);

  logic [WINDOW_W-1:0] count;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WINDOW_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/adder_measure_ctrl.sv
// Measurement sequencer for the instrumented Kogge-Stone adder: applies
// operands, lets the adder settle, clears and gates the ring-oscillator
// counter for a programmable window, then returns count and sum to the host.
module adder_measure_ctrl
  import adder_meas_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int WINDOW_W = 16,
  parameter int SETTLE   = DEF_SETTLE,
  parameter int SYNC     = DEF_SYNC
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [WIDTH-1:0]    cfg_a,
  input  logic [WIDTH-1:0]    cfg_b,
  input  logic [WINDOW_W-1:0] cfg_window,
  input  logic                abort,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [CNT_W-1:0]    res_count,
  output logic [WIDTH-1:0]    res_sum,
  output logic                res_sum_ok,
  output logic [WIDTH-1:0]    add_a,
  output logic [WIDTH-1:0]    add_b,
  output logic                ring_en,
  output logic                cnt_clear,
  input  logic [CNT_W-1:0]    cnt_value,
  input  logic [WIDTH-1:0]    sum_in
);

  // Reference sum: wraps at WIDTH bits, carry-out dropped.
  function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return a + b;
  endfunction

  meas_state_e         state_q, state_d;
  logic [WINDOW_W-1:0] window_q;
  logic                tmr_load;
  logic [WINDOW_W-1:0] tmr_val;
  logic                tmr_done;
  logic                accept;
  logic                cap_sum;
  logic                cap_cnt;

  // Phase durations: timer is loaded with (cycles - 1).
  // LOAD = SETTLE cycles, RUN = window cycles, STOP = SYNC wait + capture cycle.
  meas_timer #(
    .WINDOW_W (WINDOW_W)
  ) u_timer (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign start_ready = (state_q == IDLE);

  // Next-state, timer loads and capture strobes; abort wins over phase end.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    accept   = 1'b0;
    cap_sum  = 1'b0;
    cap_cnt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          accept   = 1'b1;
          state_d  = LOAD;
          tmr_load = 1'b1;
          tmr_val  = WINDOW_W'(SETTLE - 1);
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (tmr_done) begin
          cap_sum = 1'b1;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (abort) begin
          state_d = IDLE;
        end else if (window_q == '0) begin
          state_d  = STOP;
          tmr_load = 1'b1;
          tmr_val  = WINDOW_W'(SYNC);
        end else begin
          state_d  = RUN;
          tmr_load = 1'b1;
          tmr_val  = window_q - WINDOW_W'(1);
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (tmr_done) begin
          state_d  = STOP;
          tmr_load = 1'b1;
          tmr_val  = WINDOW_W'(SYNC);
        end
      end
      STOP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (tmr_done) begin
          cap_cnt = 1'b1;
          state_d = REPORT;
        end
      end
      REPORT: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register plus registered adder drive, counter control and result.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state_q    <= IDLE;
      window_q   <= '0;
      add_a      <= '0;
      add_b      <= '0;
      ring_en    <= 1'b0;
      cnt_clear  <= 1'b0;
      res_valid  <= 1'b0;
      res_count  <= '0;
      res_sum    <= '0;
      res_sum_ok <= 1'b0;
    end else begin
      state_q   <= state_d;
      ring_en   <= (state_d == RUN);
      cnt_clear <= (state_d == CLEAR);
      res_valid <= (state_d == REPORT);
      if (accept) begin
        add_a    <= cfg_a;
        add_b    <= cfg_b;
        window_q <= cfg_window;
      end
      if (cap_sum) begin
        res_sum    <= sum_in;
        res_sum_ok <= (sum_in == wrap_add(add_a, add_b));
      end
      if (cap_cnt) begin
        res_count <= cnt_value;
      end
    end
  end

endmodule

// File: doc/adder_measure_ctrl.md
Name: adder_measure_ctrl

Overview:
- Initiator-side sequencer for the instrumented Kogge-Stone adder.
- Accepts a measurement request (operands plus window length) from the host-side LA/firmware interface.
- Drives operands and ring enable into the instrumented adder, then clears and gates its oscillator counter.
- Captures the adder's count and sum, and returns one result record per request over a valid/ready handshake.

Parameters:
- WIDTH, 32, operand/sum width.
- WINDOW_W, 16, width of the measurement window length.
- SETTLE, 4, cycles operands are held before counting (adder settle time); must be ≥1.
- SYNC, 2, cycles waited after ring disable before sampling the counter (CDC settle); must be ≥1.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_n  in  1  synchronous active-low reset
- start_valid  in  1  measurement request
- start_ready  out  1  controller idle, request accepted on valid&ready
- cfg_a  in  WIDTH  operand A
- cfg_b  in  WIDTH  operand B
- cfg_window  in  WINDOW_W  ring-enable cycles
- abort  in  1  cancel current measurement
- res_valid  out  1  result available
- res_ready  in  1  host consumes result
- res_count  out  32  captured oscillator count
- res_sum  out  WIDTH  sum sampled from adder
- res_sum_ok  out  1  res_sum == (A+B) mod 2^WIDTH
- add_a  out  WIDTH  operand A to adder
- add_b  out  WIDTH  operand B to adder
- ring_en  out  1  ring oscillator enable
- cnt_clear  out  1  one-cycle clear of adder counter
- cnt_value  in  32  adder counter value
- sum_in  in  WIDTH  adder sum output

Behaviour:
- Reset (wb_rst_n=0 at a rising edge):
  - state=IDLE.
  - add_a, add_b, res_count, res_sum = 0.
  - ring_en, cnt_clear, res_valid, res_sum_ok = 0.
- start_ready=1 iff state==IDLE; it is combinational from the state register.
- All other outputs are registered.
- States: IDLE → LOAD → CLEAR → RUN → STOP → REPORT → IDLE.
- IDLE:
  - On start_valid&start_ready, latch cfg_a/cfg_b into add_a/add_b and cfg_window into an internal window register.
  - Go to LOAD.
  - cfg_* are ignored at all other times.
- LOAD: hold for SETTLE cycles. On the last cycle, capture sum_in into res_sum and compute res_sum_ok (WIDTH-bit wrap, carry-out dropped).
- CLEAR: cnt_clear=1 for exactly one cycle.
  - If window==0, skip RUN and go to STOP; ring_en never asserts.
- RUN: ring_en=1 for exactly window cycles (down-counter, loaded from the window register). Then go to STOP.
- STOP:
  - ring_en=0.
  - Wait SYNC cycles, then capture cnt_value into res_count.
  - Set res_valid=1 and go to REPORT.
- REPORT:
  - res_valid stays high and res_* stay stable until res_ready=1.
  - On that edge, clear res_valid and go to IDLE.
  - res_ready while res_valid=0 is ignored.
- Latency: res_valid first high SETTLE+1+window+SYNC+1 cycles after the accept edge. Defaults with window=10 give 18.
- abort=1 in LOAD/CLEAR/RUN/STOP:
  - Next cycle: state=IDLE, ring_en=0, cnt_clear=0, no result produced.
  - add_a/add_b keep their last values.
  - abort in IDLE/REPORT is ignored; a pending result is still delivered.
- Simultaneous events:
  - abort and the natural last cycle of a state: abort wins.
  - res_ready on the REPORT exit cycle with start_valid: the request is not accepted until the following cycle (state is IDLE only then).
- Reset mid-measurement: behaves as reset; ring_en drops on the next cycle.
- Window of all ones (65535) must run the full length with no wrap.

Decomposition:
- Shared package adder_meas_pkg holds:
  - the state enum (IDLE, LOAD, CLEAR, RUN, STOP, REPORT);
  - default SETTLE/SYNC constants;
  - the result record width.
- One natural sub-module: meas_timer, a loadable down-counter with a done flag, WINDOW_W wide. It is reused for the SETTLE, RUN and SYNC phases.

Test Plan:
- Reset, then A=3, B=5, window=10, cnt_value tied to 1234, sum_in=8:
  - ring_en high exactly 10 cycles;
  - cnt_clear single pulse before the ring;
  - res_valid at accept+18;
  - res_count=1234, res_sum=8, res_sum_ok=1.
- A=0xFFFFFFFF, B=1, sum_in=0 → res_sum_ok=1 (wrap). Repeat with sum_in=1 → res_sum_ok=0.
- window=0:
  - ring_en never asserts;
  - res_valid at accept+SETTLE+1+SYNC+1=8;
  - res_count = cnt_value sampled.
- abort in the 3rd RUN cycle:
  - ring_en low next cycle;
  - start_ready=1 next cycle;
  - no res_valid;
  - a new request is then accepted normally.
- Hold res_ready=0 for 20 cycles in REPORT with cnt_value changing:
  - res_* stable;
  - start_valid not accepted.
  - Then res_ready=1: state goes to IDLE and a request is accepted one cycle later.
- Assert wb_rst_n=0 during RUN: next edge ring_en=0, res_valid=0, add_a=add_b=0, start_ready=1 after release.
